// File: rtl/reg_file_access_sequencer.sv
// Sequences register-file accesses: operand pair reads, single writes, and X/Y/Z pointer updates.
// Response comes 1-4 cycles after accept. req_ready is high only in IDLE. Pointer high-byte writes are skipped when the byte does not change.
module reg_file_access_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int R_ADDR_WIDTH = 5,
  parameter int XL_ADDR      = 26,
  parameter int YL_ADDR      = 28,
  parameter int ZL_ADDR      = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_kind,
  input  logic [1:0]              req_ptr,
  input  logic [1:0]              req_mode,
  input  logic [R_ADDR_WIDTH-1:0] req_rd,
  input  logic [R_ADDR_WIDTH-1:0] req_rr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [DATA_WIDTH-1:0]   rd_value,
  output logic [DATA_WIDTH-1:0]   rr_value,
  output logic [2*DATA_WIDTH-1:0] ptr_addr,
  output logic [R_ADDR_WIDTH-1:0] rd_addr,
  output logic [R_ADDR_WIDTH-1:0] rr_addr,
  output logic                    rd_cs,
  output logic                    rd_we,
  output logic                    rd_oe,
  output logic                    rr_cs,
  output logic                    rr_oe,
  output logic [DATA_WIDTH-1:0]   rd_wdata,
  input  logic [DATA_WIDTH-1:0]   rd_rdata,
  input  logic [DATA_WIDTH-1:0]   rr_rdata
);

  localparam int PW = 2 * DATA_WIDTH;

  localparam logic [1:0] K_READ  = 2'b00;
  localparam logic [1:0] K_WRITE = 2'b01;
  localparam logic [1:0] K_PTR   = 2'b10;
  localparam logic [1:0] M_NONE  = 2'b00;
  localparam logic [1:0] M_INC   = 2'b01;
  localparam logic [1:0] M_DEC   = 2'b10;

  typedef enum logic [2:0] {IDLE, FETCH, WLO, WHI, WRITE, RESP} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              kind_q, ptr_q, mode_q;
  logic [R_ADDR_WIDTH-1:0] rd_q, rr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    err_q;
  logic [PW-1:0]           n_q;
  logic                    hi_chg_q;
  logic [DATA_WIDTH-1:0]   rd_value_q, rr_value_q;
  logic [PW-1:0]           ptr_addr_q;

  logic                    accept;
  logic                    illegal;
  logic [R_ADDR_WIDTH-1:0] lo_addr, hi_addr;
  logic [PW-1:0]           p_cur, n_cur;

  assign accept  = req_valid && (state_q == IDLE);
  assign illegal = (req_kind == 2'b11) ||
                   ((req_kind == K_PTR) && ((req_ptr == 2'b11) || (req_mode == 2'b11)));

  always_comb begin
    case (ptr_q)
      2'b00:   lo_addr = R_ADDR_WIDTH'(XL_ADDR);
      2'b01:   lo_addr = R_ADDR_WIDTH'(YL_ADDR);
      default: lo_addr = R_ADDR_WIDTH'(ZL_ADDR);
    endcase
  end
  assign hi_addr = lo_addr + R_ADDR_WIDTH'(1);

  // Pointer halves arrive on both ports in the same FETCH cycle.
  assign p_cur = {rr_rdata, rd_rdata};
  always_comb begin
    case (mode_q)
      M_INC:   n_cur = p_cur + PW'(1);
      M_DEC:   n_cur = p_cur - PW'(1);
      default: n_cur = p_cur;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rd_addr  = '0;
    rr_addr  = '0;
    rd_cs    = 1'b0;
    rd_we    = 1'b0;
    rd_oe    = 1'b0;
    rr_cs    = 1'b0;
    rr_oe    = 1'b0;
    rd_wdata = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal)                 state_d = RESP;
          else if (req_kind == K_WRITE) state_d = WRITE;
          else                         state_d = FETCH;
        end
      end
      FETCH: begin
        rd_cs = 1'b1;
        rd_oe = 1'b1;
        rr_cs = 1'b1;
        rr_oe = 1'b1;
        if (kind_q == K_READ) begin
          rd_addr = rd_q;
          rr_addr = rr_q;
        end else begin
          rd_addr = lo_addr;
          rr_addr = hi_addr;
        end
        state_d = ((kind_q == K_PTR) && (mode_q != M_NONE)) ? WLO : RESP;
      end
      WLO: begin
        rd_cs    = 1'b1;
        rd_we    = 1'b1;
        rd_addr  = lo_addr;
        rd_wdata = n_q[DATA_WIDTH-1:0];
        state_d  = hi_chg_q ? WHI : RESP;
      end
      WHI: begin
        rd_cs    = 1'b1;
        rd_we    = 1'b1;
        rd_addr  = hi_addr;
        rd_wdata = n_q[PW-1:DATA_WIDTH];
        state_d  = RESP;
      end
      WRITE: begin
        rd_cs    = 1'b1;
        rd_we    = 1'b1;
        rd_addr  = rd_q;
        rd_wdata = wdata_q;
        state_d  = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      kind_q     <= '0;
      ptr_q      <= '0;
      mode_q     <= '0;
      rd_q       <= '0;
      rr_q       <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      n_q        <= '0;
      hi_chg_q   <= 1'b0;
      rd_value_q <= '0;
      rr_value_q <= '0;
      ptr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        kind_q  <= req_kind;
        ptr_q   <= req_ptr;
        mode_q  <= req_mode;
        rd_q    <= req_rd;
        rr_q    <= req_rr;
        wdata_q <= req_wdata;
        err_q   <= illegal;
      end
      if (state_q == FETCH) begin
        if (kind_q == K_READ) begin
          rd_value_q <= rd_rdata;
          rr_value_q <= rr_rdata;
        end else begin
          n_q        <= n_cur;
          hi_chg_q   <= (n_cur[PW-1:DATA_WIDTH] != p_cur[PW-1:DATA_WIDTH]);
          ptr_addr_q <= (mode_q == M_DEC) ? n_cur : p_cur;
        end
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) && err_q;
  assign rd_value   = rd_value_q;
  assign rr_value   = rr_value_q;
  assign ptr_addr   = ptr_addr_q;

endmodule

// File: doc/reg_file_access_sequencer.md
REG_FILE_ACCESS_SEQUENCER -- requirements
Module: reg_file_access_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, 8, register width in bits; pointer width SHALL be 2*DATA_WIDTH.
REQ-002 Parameter R_ADDR_WIDTH, 5, register-file address width.
REQ-003 Parameters XL_ADDR/YL_ADDR/ZL_ADDR, 26/28/30, pointer low-byte addresses; high byte SHALL be low+1.
REQ-004 Clocking is decided: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  1 / req_ready  out  1  request handshake.
REQ-008 req_kind  in  2  00 read pair, 01 write Rd, 10 pointer op, 11 illegal.
REQ-009 req_ptr  in  2  00 X, 01 Y, 10 Z, 11 illegal; req_mode  in  2  00 none, 01 post-inc, 10 pre-dec, 11 illegal.
REQ-010 req_rd, req_rr  in  R_ADDR_WIDTH  register operands; req_wdata  in  DATA_WIDTH  write value.
REQ-011 resp_valid  out  1  one-cycle completion pulse; resp_err  out  1  illegal request flag.
REQ-012 rd_value, rr_value  out  DATA_WIDTH  captured operands; ptr_addr  out  2*DATA_WIDTH  effective address.
REQ-013 rd_addr, rr_addr  out  R_ADDR_WIDTH; rd_cs, rd_we, rd_oe, rr_cs, rr_oe  out  1  register-file port controls.
REQ-014 rd_wdata  out  DATA_WIDTH; rd_rdata, rr_rdata  in  DATA_WIDTH, asynchronous read, valid in the cycle cs&oe are high.

Function
REQ-015 FSM states: IDLE, FETCH, WLO, WHI, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Request accepted on rising edge with req_valid&req_ready; all req_* fields latched then.
REQ-017 Read pair: FETCH drives rd_addr=req_rd, rr_addr=req_rr, both cs/oe=1, we=0; data captured into rd_value/rr_value; then RESP (resp_valid at accept+2).
REQ-018 Write Rd: WRITE drives rd_addr=req_rd, rd_cs=1, rd_we=1, rd_oe=0, rd_wdata=req_wdata; then RESP (accept+2).
REQ-019 Pointer op: FETCH reads low byte on rd port, high byte on rr port same cycle; old value P captured.
REQ-020 New value N = P+1 (post-inc) or P-1 (pre-dec), modulo 2^(2*DATA_WIDTH); mode none: N=P.
REQ-021 ptr_addr SHALL be P for none/post-inc and N for pre-dec.
REQ-022 Mode none: FETCH -> RESP, no write (accept+2).
REQ-023 Otherwise WLO writes N low byte via rd port; WHI writes N high byte via rd port only if high byte changed, else skipped.
REQ-024 Latency: high byte unchanged -> resp at accept+3; changed -> accept+4.
REQ-025 Wrap: 0xFFFF post-inc -> N=0x0000, both bytes written; 0x0000 pre-dec -> N=0xFFFF, both written, ptr_addr=0xFFFF.
REQ-026 Illegal kind/ptr/mode: no register-file access; RESP with resp_err=1 at accept+1.
REQ-027 RESP lasts one cycle then IDLE; rd_value, rr_value, ptr_addr hold until next capture.
REQ-028 In states without port use: cs/we/oe=0, addresses and rd_wdata=0; never X or Z.
REQ-029 rr_we does not exist; rr port SHALL never write.

Reset
REQ-030 reset SHALL force IDLE immediately; req_ready=1 in IDLE after reset; all other outputs 0.
REQ-031 reset mid-operation SHALL abort: no further writes, no resp_valid for the aborted request.

Verification
REQ-032 Read pair rd=3, rr=17 holding 0x5A/0xC3 -> resp at accept+2, rd_value=0x5A, rr_value=0xC3, no we.
REQ-033 Write rd=5, wdata=0xA7 -> one cycle rd_we=1, rd_addr=5, rd_wdata=0xA7; resp at accept+2.
REQ-034 X=0x12FF post-inc -> writes r26=0x00, r27=0x13, ptr_addr=0x12FF, resp at accept+4.
REQ-035 Z=0x0000 pre-dec -> r30=0xFF, r31=0xFF, ptr_addr=0xFFFF; Y=0x0410 pre-dec -> only r28=0x0F, resp accept+3.
REQ-036 kind=11 -> resp_err=1 at accept+1, all cs=0; reset asserted in WLO -> IDLE, no WHI write, no resp.
REQ-037 req_valid held through busy period -> second request accepted only in cycle after RESP.
